z80_ld16_immed_seq: RTL and testbench

Micro-sequencer that executes the 16-bit immediate load LD dd,nn (opcode 00dd0001, nn little-endian) once the opcode byte has been fetched. It issues the two operand-byte memory reads, assembles nn, writes register pair dd through the register-file write port and advances PC by 3. It sits between the core's decode stage and the shared memory/register-file ports. Optionally, it emits a Z80FI retirement record.

---
 rtl/z80_seq_pkg.sv | 27 ++
 rtl/z80_ld16_immed_seq_if.sv | 10 +
 rtl/z80_wait_timer.sv | 25 ++
 rtl/z80_ld16_immed_seq.sv | 172 +++++++++++++++++
 tb/tb_z80_ld16_immed_seq.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_seq_pkg.sv
// Shared definitions for the Z80 multi-byte micro-sequencers.
package z80_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    WB    = 2'd3
  } seq_state_t;

  localparam logic [3:0] REG_BC = 4'd8;
  localparam logic [3:0] REG_DE = 4'd9;
  localparam logic [3:0] REG_HL = 4'd10;
  localparam logic [3:0] REG_SP = 4'd11;

  localparam logic [7:0] LD16_MASK  = 8'hCF;
  localparam logic [7:0] LD16_MATCH = 8'h01;

  function automatic logic is_ld16(input logic [7:0] op);
    return (op & LD16_MASK) == LD16_MATCH;
  endfunction

  function automatic logic [3:0] pair_wnum(input logic [1:0] dd);
    return REG_BC | {2'b00, dd};
  endfunction

endpackage

// File: rtl/z80_ld16_immed_seq_if.sv
// Shared memory read port between a sequencer (master) and the memory (slave).
interface z80_ld16_immed_seq_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/z80_wait_timer.sv
// Per-read wait-cycle counter; expired is high while the count equals WAIT_MAX.
module z80_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);
  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (tick && !expired)
      count <= count + 1'b1;
  end

  assign expired = (count == CW'(WAIT_MAX));
endmodule

// File: rtl/z80_ld16_immed_seq.sv
// LD dd,nn micro-sequencer: two operand reads, register-pair and PC write-back.
// Define Z80FI_TRACE_EN to add the Z80FI retirement record ports.
module z80_ld16_immed_seq
  import z80_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [7:0]                  opcode,
  input  logic [15:0]                 pc_in,
  output logic                        busy,
  z80_ld16_immed_seq_if.master        mem,
  output logic                        reg_we,
  output logic [3:0]                  reg_wnum,
  output logic [15:0]                 reg_wdata,
  output logic                        pc_we,
  output logic [15:0]                 pc_wdata,
  output logic                        done,
  output logic                        illegal,
  output logic                        timeout
`ifdef Z80FI_TRACE_EN
  ,
  output logic                        z80fi_valid,
  output logic [31:0]                 z80fi_insn,
  output logic [2:0]                  z80fi_insn_len,
  output logic [15:0]                 z80fi_pc_rdata,
  output logic [15:0]                 z80fi_pc_wdata,
  output logic [3:0]                  z80fi_reg_wnum,
  output logic [15:0]                 z80fi_reg_wdata
`endif
);

  seq_state_t  state;
  logic [1:0]  dd;
  logic [15:0] pc;
  logic [7:0]  nn_lo;
  logic        in_read;
  logic        expired;
`ifdef Z80FI_TRACE_EN
  logic [7:0]  op;
`endif

  assign in_read = (state == RD_LO) || (state == RD_HI);

  // Counter is held clear outside reads and on every accepted ack, so each read starts at zero
  z80_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_read || mem.mem_ack),
    .tick    (in_read && !mem.mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dd           <= '0;
      pc           <= '0;
      nn_lo        <= '0;
      busy         <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      reg_we       <= 1'b0;
      reg_wnum     <= '0;
      reg_wdata    <= '0;
      pc_we        <= 1'b0;
      pc_wdata     <= '0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      timeout      <= 1'b0;
`ifdef Z80FI_TRACE_EN
      op              <= '0;
      z80fi_valid     <= 1'b0;
      z80fi_insn      <= '0;
      z80fi_insn_len  <= '0;
      z80fi_pc_rdata  <= '0;
      z80fi_pc_wdata  <= '0;
      z80fi_reg_wnum  <= '0;
      z80fi_reg_wdata <= '0;
`endif
    end else begin
      reg_we    <= 1'b0;
      reg_wnum  <= '0;
      reg_wdata <= '0;
      pc_we     <= 1'b0;
      pc_wdata  <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
`ifdef Z80FI_TRACE_EN
      z80fi_valid     <= 1'b0;
      z80fi_insn      <= '0;
      z80fi_insn_len  <= '0;
      z80fi_pc_rdata  <= '0;
      z80fi_pc_wdata  <= '0;
      z80fi_reg_wnum  <= '0;
      z80fi_reg_wdata <= '0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (is_ld16(opcode)) begin
              dd           <= opcode[5:4];
              pc           <= pc_in;
              busy         <= 1'b1;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= pc_in + 16'd1;
              state        <= RD_LO;
`ifdef Z80FI_TRACE_EN
              op           <= opcode;
`endif
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        RD_LO: begin
          if (mem.mem_ack) begin
            nn_lo        <= mem.mem_rdata;
            mem.mem_addr <= pc + 16'd2;
            state        <= RD_HI;
          end else if (expired) begin
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b1;
            state        <= IDLE;
          end
        end
        RD_HI: begin
          if (mem.mem_ack) begin
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            reg_we       <= 1'b1;
            reg_wnum     <= pair_wnum(dd);
            reg_wdata    <= {mem.mem_rdata, nn_lo};
            pc_we        <= 1'b1;
            pc_wdata     <= pc + 16'd3;
            done         <= 1'b1;
            state        <= WB;
`ifdef Z80FI_TRACE_EN
            z80fi_valid     <= 1'b1;
            z80fi_insn      <= {8'h00, mem.mem_rdata, nn_lo, op};
            z80fi_insn_len  <= 3'd3;
            z80fi_pc_rdata  <= pc;
            z80fi_pc_wdata  <= pc + 16'd3;
            z80fi_reg_wnum  <= pair_wnum(dd);
            z80fi_reg_wdata <= {mem.mem_rdata, nn_lo};
`endif
          end else if (expired) begin
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b1;
            state        <= IDLE;
          end
        end
        WB: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_ld16_immed_seq.sv
// Randomized bench for z80_ld16_immed_seq against a cycle-timeline model.
// Build with Z80FI_TRACE_EN defined to also check the retirement record.
module tb_z80_ld16_immed_seq;
  localparam int unsigned WM = 3;
  localparam int WMI = 3;

  typedef struct packed {
    logic        busy;
    logic        req;
    logic [15:0] addr;
    logic        rwe;
    logic [3:0]  wnum;
    logic [15:0] wdata;
    logic        pwe;
    logic [15:0] pwdata;
    logic        done;
    logic        ill;
    logic        tmo;
    logic [31:0] insn;
    logic [15:0] prd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = '0;
  logic [15:0] pc_in = '0;
  logic        busy, reg_we, pc_we, done, illegal, timeout;
  logic [3:0]  reg_wnum;
  logic [15:0] reg_wdata, pc_wdata;
`ifdef Z80FI_TRACE_EN
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_pc_rdata, z80fi_pc_wdata, z80fi_reg_wdata;
  logic [3:0]  z80fi_reg_wnum;
`endif

  z80_ld16_immed_seq_if mem_if();

  z80_ld16_immed_seq #(.WAIT_MAX(WM)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opcode    (opcode),
    .pc_in     (pc_in),
    .busy      (busy),
    .mem       (mem_if),
    .reg_we    (reg_we),
    .reg_wnum  (reg_wnum),
    .reg_wdata (reg_wdata),
    .pc_we     (pc_we),
    .pc_wdata  (pc_wdata),
    .done      (done),
    .illegal   (illegal),
    .timeout   (timeout)
`ifdef Z80FI_TRACE_EN
    ,
    .z80fi_valid     (z80fi_valid),
    .z80fi_insn      (z80fi_insn),
    .z80fi_insn_len  (z80fi_insn_len),
    .z80fi_pc_rdata  (z80fi_pc_rdata),
    .z80fi_pc_wdata  (z80fi_pc_wdata),
    .z80fi_reg_wnum  (z80fi_reg_wnum),
    .z80fi_reg_wdata (z80fi_reg_wdata)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_err = 0;
  exp_t exp_tab[int];
  logic [7:0] ack_tab[int];
  bit   rd_tab[int];
  bit   noisy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t exp_at(input int c);
    exp_t e;
    if (exp_tab.exists(c)) e = exp_tab[c];
    else e = '0;
    return e;
  endfunction

  // Every cycle: anything not planned by the timeline must be quiet
  always @(negedge clk) begin
    exp_t e;
    e = exp_at(cyc);
    check("busy",      32'(busy),             32'(e.busy));
    check("mem_req",   32'(mem_if.mem_req),   32'(e.req));
    check("mem_addr",  32'(mem_if.mem_addr),  32'(e.addr));
    check("reg_we",    32'(reg_we),           32'(e.rwe));
    check("reg_wnum",  32'(reg_wnum),         32'(e.wnum));
    check("reg_wdata", 32'(reg_wdata),        32'(e.wdata));
    check("pc_we",     32'(pc_we),            32'(e.pwe));
    check("pc_wdata",  32'(pc_wdata),         32'(e.pwdata));
    check("done",      32'(done),             32'(e.done));
    check("illegal",   32'(illegal),          32'(e.ill));
    check("timeout",   32'(timeout),          32'(e.tmo));
`ifdef Z80FI_TRACE_EN
    check("z80fi_valid",     32'(z80fi_valid),     32'(e.done));
    check("z80fi_insn",      z80fi_insn,           e.insn);
    check("z80fi_insn_len",  32'(z80fi_insn_len),  e.done ? 32'd3 : 32'd0);
    check("z80fi_pc_rdata",  32'(z80fi_pc_rdata),  32'(e.prd));
    check("z80fi_pc_wdata",  32'(z80fi_pc_wdata),  32'(e.pwdata));
    check("z80fi_reg_wnum",  32'(z80fi_reg_wnum),  32'(e.wnum));
    check("z80fi_reg_wdata", 32'(z80fi_reg_wdata), 32'(e.wdata));
`endif
  end

  // Timeline model: wait count > WM means that read never gets an ack
  task automatic plan(input int s, input logic [7:0] op, input logic [15:0] pc,
                      input int w0, input int w1, input logic [7:0] lo, input logic [7:0] hi,
                      output int nf);
    exp_t        e;
    int          c;
    int          w[2];
    logic [15:0] a;
    w[0] = w0;
    w[1] = w1;
    if (!(op[7:6] == 2'b00 && op[3:0] == 4'b0001)) begin
      e = exp_at(s + 1); e.ill = 1'b1; exp_tab[s + 1] = e;
      nf = s + 1;
      return;
    end
    c = s + 1;
    for (int r = 0; r < 2; r++) begin
      a = pc + 16'(r + 1);
      for (int k = 0; k <= w[r] && k <= WMI; k++) begin
        e = exp_at(c + k); e.busy = 1'b1; e.req = 1'b1; e.addr = a; exp_tab[c + k] = e;
        rd_tab[c + k] = 1'b1;
      end
      if (w[r] > WMI) begin
        e = exp_at(c + WMI + 1); e.tmo = 1'b1; exp_tab[c + WMI + 1] = e;
        nf = c + WMI + 1;
        return;
      end
      ack_tab[c + w[r]] = (r == 0) ? lo : hi;
      c += w[r] + 1;
    end
    e = exp_at(c);
    e.busy = 1'b1; e.rwe = 1'b1; e.wnum = 4'd8 + 4'(op[5:4]); e.wdata = {hi, lo};
    e.pwe = 1'b1; e.pwdata = pc + 16'd3; e.done = 1'b1; e.insn = {8'h00, hi, lo, op}; e.prd = pc;
    exp_tab[c] = e;
    nf = c + 1;
  endtask

  // Called at posedge+1; drives cycles up to (not including) upto
  task automatic drive(input int upto, input int s, input logic [7:0] op, input logic [15:0] pc);
    bit is_busy;
    while (cyc < upto) begin
      is_busy = exp_tab.exists(cyc) && exp_tab[cyc].busy;
      if (cyc == s) begin
        start = 1'b1; opcode = op; pc_in = pc;
      end else if (is_busy && (noisy || $urandom_range(0, 3) == 0)) begin
        start = 1'b1; opcode = noisy ? 8'h01 : 8'($urandom); pc_in = 16'($urandom);
      end else begin
        start = 1'b0; opcode = 8'($urandom); pc_in = 16'($urandom);
      end
      if (ack_tab.exists(cyc)) begin
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = ack_tab[cyc];
      end else begin
        mem_if.mem_ack = !rd_tab.exists(cyc) && (noisy || $urandom_range(0, 2) == 0);
        mem_if.mem_rdata = 8'($urandom);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    mem_if.mem_ack = 1'b0;
  endtask

  task automatic txn(input logic [7:0] op, input logic [15:0] pc, input int w0, input int w1,
                     input logic [7:0] lo, input logic [7:0] hi, input int gap, output int s);
    int nf;
    s = cyc + gap;
    plan(s, op, pc, w0, w1, lo, hi, nf);
    drive(nf, s, op, pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int nf;
    logic [7:0] op;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // LD HL,1234 at 0100, with start and ack noise everywhere they must be ignored
    noisy = 1'b1;
    txn(8'h21, 16'h0100, 0, 0, 8'h34, 8'h12, 1, s);
    noisy = 1'b0;
    check("pin_t1_addr_lo", 32'(exp_at(s + 1).addr), 32'h0101);
    check("pin_t1_addr_hi", 32'(exp_at(s + 2).addr), 32'h0102);
    check("pin_t1_done",    32'(exp_at(s + 3).done), 32'd1);
    check("pin_t1_wnum",    32'(exp_at(s + 3).wnum), 32'd10);
    check("pin_t1_wdata",   32'(exp_at(s + 3).wdata), 32'h1234);
    check("pin_t1_pc",      32'(exp_at(s + 3).pwdata), 32'h0103);
    check("pin_t1_insn",    exp_at(s + 3).insn, 32'h0012_3421);

    // LD SP,ABCD at FFFF with two waits per read
    txn(8'h31, 16'hFFFF, 2, 2, 8'hCD, 8'hAB, 2, s);
    check("pin_t2_addr_lo", 32'(exp_at(s + 1).addr), 32'h0000);
    check("pin_t2_addr_hi", 32'(exp_at(s + 4).addr), 32'h0001);
    check("pin_t2_done",    32'(exp_at(s + 7).done), 32'd1);
    check("pin_t2_wnum",    32'(exp_at(s + 7).wnum), 32'd11);
    check("pin_t2_wdata",   32'(exp_at(s + 7).wdata), 32'hABCD);
    check("pin_t2_pc",      32'(exp_at(s + 7).pwdata), 32'h0002);

    // PC FFFE wrap, one wait on the high read (WAIT_MAX boundary on the low one)
    txn(8'h01, 16'hFFFE, WMI, 1, 8'h55, 8'hAA, 0, s);
    check("pin_t3_addr_hi", 32'(exp_at(s + WMI + 2).addr), 32'h0000);
    check("pin_t3_pc",      32'(exp_at(s + WMI + 4).pwdata), 32'h0001);

    // Illegal opcodes
    txn(8'h22, 16'h1000, 0, 0, 8'h00, 8'h00, 1, s);
    check("pin_ill_22", 32'(exp_at(s + 1).ill), 32'd1);
    txn(8'h41, 16'h1000, 0, 0, 8'h00, 8'h00, 0, s);
    check("pin_ill_41", 32'(exp_at(s + 1).ill), 32'd1);

    // Never-acked low read
    txn(8'h11, 16'h3000, WMI + 1, 0, 8'h00, 8'h00, 1, s);
    check("pin_tmo_req", 32'(exp_at(s + 4).req), 32'd1);
    check("pin_tmo",     32'(exp_at(s + 5).tmo), 32'd1);

    // Asynchronous reset during RD_HI
    s = cyc + 1;
    plan(s, 8'h01, 16'h4000, 0, 3, 8'h11, 8'h22, nf);
    drive(s + 3, s, 8'h01, 16'h4000);
    reset_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_addr",    32'(mem_if.mem_addr), 32'd0);
    for (int k = s + 3; k <= nf + 2; k++) begin
      if (exp_tab.exists(k)) exp_tab.delete(k);
      if (ack_tab.exists(k)) ack_tab.delete(k);
      if (rd_tab.exists(k)) rd_tab.delete(k);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    txn(8'h11, 16'h2000, 0, 0, 8'h78, 8'h56, 1, s);
    check("pin_rst_wnum",  32'(exp_at(s + 3).wnum), 32'd9);
    check("pin_rst_wdata", 32'(exp_at(s + 3).wdata), 32'h5678);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int w0;
      int w1;
      if ($urandom_range(0, 3) != 0) op = {2'b00, 2'($urandom), 4'b0001};
      else op = 8'($urandom);
      w0 = ($urandom_range(0, 9) == 0) ? WMI + 1 : int'($urandom_range(0, WM));
      w1 = ($urandom_range(0, 9) == 0) ? WMI + 1 : int'($urandom_range(0, WM));
      txn(op, 16'($urandom), w0, w1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), s);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
